// File: rtl/ha_exerciser_pkg.sv
// Shared types and golden model for the half-adder exerciser.
package ha_exerciser_pkg;

    // Run-control states of the exerciser.
    typedef enum logic [1:0] {
        HA_EX_IDLE   = 2'd0,
        HA_EX_SETTLE = 2'd1,
        HA_EX_CHECK  = 2'd2,
        HA_EX_DONE   = 2'd3
    } ha_ex_state_e;

    // Number of distinct input vectors of a half adder.
    localparam int unsigned HA_NUM_VEC = 4;

    // Golden half adder: vec = {in1,in2}, result = {carry,sum}.
    function automatic logic [1:0] ha_expected(input logic [1:0] vec);
        return {vec[1] & vec[0], vec[1] ^ vec[0]};
    endfunction

endpackage : ha_exerciser_pkg

// File: rtl/ha_exerciser.sv
// Clocked exerciser for a half adder: sweeps all four input vectors for
// NUM_PASSES passes, holds each for SETTLE_CYCLES before checking, and
// reports a saturating error count plus a pass/fail verdict.
// Optional build macro: HA_EXERCISER_STOP_ON_FAIL_EN ends the run at the
// first mismatching vector instead of completing the sweep.
module ha_exerciser
    import ha_exerciser_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned NUM_PASSES    = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             in1,
    output logic             in2,
    input  logic             sum,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       vec_idx
);

    localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(NUM_PASSES - 1);
    localparam logic [1:0]        VEC_LAST    = 2'(HA_NUM_VEC - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

`ifdef HA_EXERCISER_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    ha_ex_state_e      state;
    logic [SET_W-1:0]  settle_cnt;
    logic [PASS_W-1:0] pass_cnt;

    logic              mismatch_c;
    logic [ERR_W-1:0]  err_nxt_c;

    // The vector register drives the DUT operands directly.
    assign in1 = vec_idx[1];
    assign in2 = vec_idx[0];

    // Compare the returned result with the golden model; both bits wrong
    // still counts as a single error.
    always_comb begin
        mismatch_c = 1'b0;
        err_nxt_c  = err_cnt;
        mismatch_c = ({carry, sum} != ha_expected(vec_idx));
        if (mismatch_c && (err_cnt != ERR_MAX)) begin
            err_nxt_c = err_cnt + ERR_W'(1);
        end
    end

    // Run-control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HA_EX_IDLE;
            vec_idx    <= 2'd0;
            settle_cnt <= '0;
            pass_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                HA_EX_IDLE: begin
                    if (start) begin
                        state      <= HA_EX_SETTLE;
                        vec_idx    <= 2'd0;
                        settle_cnt <= '0;
                        pass_cnt   <= '0;
                        err_cnt    <= '0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                HA_EX_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= HA_EX_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                HA_EX_CHECK: begin
                    err_cnt <= err_nxt_c;
                    if (STOP_ON_FAIL && mismatch_c) begin
                        // Hold the failing vector for inspection.
                        state <= HA_EX_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                    end else if (vec_idx == VEC_LAST) begin
                        if (pass_cnt == PASS_LAST) begin
                            // Last vector of last pass: vec_idx stays at 3.
                            state <= HA_EX_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_nxt_c == '0);
                        end else begin
                            pass_cnt <= pass_cnt + PASS_W'(1);
                            vec_idx  <= 2'd0;
                            state    <= HA_EX_SETTLE;
                        end
                    end else begin
                        vec_idx <= vec_idx + 2'd1;
                        state   <= HA_EX_SETTLE;
                    end
                end
                HA_EX_DONE: begin
                    state <= HA_EX_IDLE;
                end
                default: begin
                    state <= HA_EX_IDLE;
                end
            endcase
        end
    end

endmodule : ha_exerciser

// File: doc/ha_exerciser.md
# ha_exerciser

Clocked self-checking exerciser that drives the input side of the half-adder interface (`in1`, `in2`) and checks the returned `sum`/`carry` against a golden model. It sits on the TEST end of `ha_interface` in place of a free-running initial-block bench. It sweeps all four input vectors for a programmable number of passes, with a programmable settle time per vector, and reports an error count plus a pass/fail verdict.

## Interface
- `SETTLE_CYCLES`, default 1: cycles a vector is held before checking; legal range ≥ 1.
- `NUM_PASSES`, default 1: full 4-vector sweeps per run; legal range ≥ 1.
- `ERR_W`, default 8: width of the error counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `start`  in  1  run request; sampled in IDLE only.
- `in1`  out  1  DUT operand A, registered.
- `in2`  out  1  DUT operand B, registered.
- `sum`  in  1  DUT sum.
- `carry`  in  1  DUT carry.
- `busy`  out  1  high in SETTLE and CHECK.
- `done`  out  1  single-cycle pulse at end of run.
- `pass`  out  1  verdict of the last completed run; held until the next start.
- `err_cnt`  out  ERR_W  saturating mismatch count; cleared on start.
- `vec_idx`  out  2  current vector, equal to `{in1,in2}`.

## Operation
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE → SETTLE when `start`=1:
  - load vector 0 (`{in1,in2}`=2'b00).
  - clear `err_cnt`, the pass counter and the settle counter.
- SETTLE → CHECK after exactly `SETTLE_CYCLES` cycles in SETTLE.
- CHECK (one cycle): compare `sum` with `in1^in2` and `carry` with `in1&in2`.
  - Any mismatch increments `err_cnt` by 1, saturating at 2^ERR_W−1.
  - A mismatch on both bits of one vector counts as 1.
- CHECK → SETTLE with the next vector (`vec_idx`+1, 2-bit wrap 3→0). On wrap, the pass counter increments.
- CHECK → DONE when the pass counter reaches `NUM_PASSES` on wrap.
  - `vec_idx` stays at 3; it does not wrap.
  - `pass` <= (final `err_cnt` == 0).
- DONE → IDLE unconditionally after one cycle. `done`=1 only while in DONE.
- `start` is ignored outside IDLE, including the DONE cycle.
- Reset values: `in1`=0, `in2`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `vec_idx`=0, state IDLE.
- Reset asserted mid-run aborts immediately to reset values. No `done` is issued and `pass` is not updated.

## Timing
- Vector change and `busy` rise occur on the same edge.
- Each vector occupies `SETTLE_CYCLES`+1 cycles: SETTLE cycles plus one CHECK cycle.
- `sum`/`carry` are sampled at the edge leaving CHECK.
- `err_cnt` updates on the same edge.
- Start edge to DONE entry: NUM_PASSES·4·(SETTLE_CYCLES+1) cycles. Default = 8.
- `pass` is valid in the DONE cycle and later.

## Configuration
- `HA_EXERCISER_STOP_ON_FAIL_EN` defined: the first mismatch in CHECK goes directly to DONE.
  - `err_cnt`=1, `pass`=0.
  - `vec_idx` holds the failing vector.
- Undefined: the run always completes every vector of every pass, accumulating errors.

## Structure
- Package `ha_exerciser_pkg` holds:
  - state enum `ha_ex_state_e`.
  - constant `HA_NUM_VEC`=4.
  - function `ha_expected(logic [1:0] vec)` returning `{carry,sum}`.
- No sub-module: settle counter, pass counter and golden model are small enough to stay inline.

## Test plan
- Correct half adder, defaults, `start` pulse at cycle 0 → `done` at cycle 8, `pass`=1, `err_cnt`=0, `in1`/`in2` back at 1/1.
- DUT with `carry` stuck at 0, defaults → only vector 3 fails; `err_cnt`=1, `pass`=0.
- DUT with `sum` inverted, `NUM_PASSES`=2, `SETTLE_CYCLES`=3 → `done` at cycle 32, `err_cnt`=8.
- DUT with `sum` inverted, `ERR_W`=2, `NUM_PASSES`=2 → `err_cnt` saturates at 3, `pass`=0.
- `start` re-pulsed while busy, then `rst_n` low at cycle 5 → run aborts, no `done`, all outputs at reset values, next `start` runs cleanly.
- With `HA_EXERCISER_STOP_ON_FAIL_EN`, `sum` stuck at 0 → fails at vector 1; `done` at cycle 4, `vec_idx`=1, `err_cnt`=1.
